// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: op encodings and FSM states.
package alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: AND / OR / full-add with optional B inversion and a 4:1
// result select. Purely combinational; the sequencer reuses it once per bit.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_cin,
  input  logic       i_b_inv,
  input  logic       i_less,
  input  logic [1:0] i_op,
  output logic       o_result,
  output logic       o_cout,
  output logic       o_sum
);

  logic w_b;

  assign w_b    = i_b ^ i_b_inv;
  assign o_sum  = i_a ^ w_b ^ i_cin;
  assign o_cout = (i_a & w_b) | (i_cin & (i_a ^ w_b));

  // Select the slice output for the requested operation
  always_comb begin
    o_result = 1'b0;
    case (i_op)
      OP_AND:  o_result = i_a & w_b;
      OP_OR:   o_result = i_a | w_b;
      OP_ADD:  o_result = o_sum;
      default: o_result = i_less;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: evaluates one WIDTH-bit operation LSB first through
// a single alu_bit_slice, one bit per clock, then presents the word on a
// valid/ready handshake. Optional macro ALU_SERIAL_OVF_EN enables signed
// overflow detection and overflow-corrected set-less-than.
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       alu_op,
  input  logic             b_negate,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic [WIDTH-1:0] r_result;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic             r_neg;
  logic             r_carry;
  logic             r_zero;
  logic             r_ovf;

  logic             w_res;
  logic             w_cout;
  logic             w_sum;
  logic             w_ovf;
  logic             w_less;
  logic [WIDTH-1:0] w_final_sh;
  logic [WIDTH-1:0] w_final;

  alu_bit_slice u_slice (
    .i_a      (r_a_sh[0]),
    .i_b      (r_b_sh[0]),
    .i_cin    (r_carry),
    .i_b_inv  (r_neg),
    .i_less   (1'b0),
    .i_op     (r_op),
    .o_result (w_res),
    .o_cout   (w_cout),
    .o_sum    (w_sum)
  );

  // Result word as it will look once the current slice bit is shifted in.
  // The shift operator keeps every bit of the register in use.
  assign w_final_sh = {w_res, {(WIDTH-1){1'b0}}} | (r_res_sh >> 1);

  // During the MSB pass the carry flop holds the MSB carry-in, so overflow
  // and SLT are resolved from it and the slice outputs in the same cycle.
`ifdef ALU_SERIAL_OVF_EN
  assign w_ovf  = r_op[1] & (r_carry ^ w_cout);
  assign w_less = w_sum ^ w_ovf;
`else
  assign w_ovf  = 1'b0;
  assign w_less = w_sum;
`endif

  assign w_final = (r_op == OP_SLT) ? {{(WIDTH-1){1'b0}}, w_less} : w_final_sh;

  assign start_ready = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign res_valid   = (r_state == ST_DONE);
  assign result      = r_result;
  assign zero        = r_zero;
  assign overflow    = r_ovf;

  // Sequencer FSM: accept operands, step one bit per cycle, hold result until taken
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_cnt    <= '0;
      r_op     <= OP_AND;
      r_neg    <= 1'b0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_valid) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_res_sh <= '0;
            r_op     <= alu_op;
            r_neg    <= (alu_op == OP_SLT) ? 1'b1 : b_negate;
            r_carry  <= (alu_op == OP_SLT) ? 1'b1 : b_negate;
            r_cnt    <= '0;
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_res_sh <= w_final_sh;
          r_carry  <= w_cout;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_BIT) begin
            r_result <= w_final;
            r_zero   <= (w_final == '0);
            r_ovf    <= w_ovf;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq: directed vector table, random
// operations against an arithmetic reference model, backpressure and
// mid-operation reset sequences. Honors ALU_SERIAL_OVF_EN like the design.
module tb_alu_serial_seq;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [1:0]    alu_op = 2'b00;
  logic          b_negate = 1'b0;
  logic [W-1:0]  result;
  logic          zero;
  logic          overflow;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic          busy;

  int checks = 0;
  int errors = 0;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .alu_op      (alu_op),
    .b_negate    (b_negate),
    .result      (result),
    .zero        (zero),
    .overflow    (overflow),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [31:0] va;
    logic [31:0] vb;
    logic [1:0]  op;
    logic        neg;
    logic [31:0] er;
    logic        ez;
    logic        eo;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain two's-complement arithmetic on whole words.
  function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                input logic [1:0] op, input logic bneg,
                                output logic [31:0] r, output logic z, output logic o);
    logic        neg;
    logic [31:0] bb;
    logic [32:0] s;
    logic        sov;
    neg = (op == 2'b11) ? 1'b1 : bneg;
    bb  = neg ? ~mb : mb;
    s   = {1'b0, ma} + {1'b0, bb} + 33'(neg);
    sov = (ma[31] == bb[31]) && (s[31] != ma[31]);
    case (op)
      2'b00: r = ma & bb;
      2'b01: r = ma | bb;
      2'b10: r = s[31:0];
      default: begin
`ifdef ALU_SERIAL_OVF_EN
        r = {31'b0, ($signed(ma) < $signed(mb))};
`else
        r = {31'b0, s[31]};
`endif
      end
    endcase
    z = (r == 32'd0);
`ifdef ALU_SERIAL_OVF_EN
    o = op[1] ? sov : 1'b0;
`else
    o = 1'b0;
`endif
  endfunction

  // Present one operation and wait for the accepting edge; operands are then scrambled.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_, input logic [1:0] op, input logic neg);
    int n;
    n = 0;
    while (!start_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("start_ready_wait", {31'b0, start_ready}, 32'd1);
    a = ta; b = tb_; alu_op = op; b_negate = neg; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    a = $urandom; b = $urandom; alu_op = 2'($urandom_range(0, 3)); b_negate = 1'($urandom_range(0, 1));
  endtask

  // Count edges after the accepting edge until res_valid; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= W + 10; n++) begin
      @(posedge clk); #1;
      if (res_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic do_op(input string nm, input logic [31:0] ta, input logic [31:0] tb_,
                       input logic [1:0] op, input logic neg,
                       input logic [31:0] er, input logic ez, input logic eo);
    int lat;
    start_op(ta, tb_, op, neg);
    wait_done(lat);
    chk({nm, "_latency"}, 32'(lat), 32'(W));
    chk({nm, "_result"}, result, er);
    chk({nm, "_zero"}, {31'b0, zero}, {31'b0, ez});
    chk({nm, "_overflow"}, {31'b0, overflow}, {31'b0, eo});
    $display("txn %s a=%h b=%h op=%0d neg=%0d -> result=%h zero=%0d ovf=%0d lat=%0d",
             nm, ta, tb_, op, neg, result, zero, overflow, lat);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk({nm, "_idle_ready"}, {31'b0, start_ready}, 32'd1);
    chk({nm, "_idle_valid"}, {31'b0, res_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, er;
    logic [1:0]  rop;
    logic        rneg, ez, eo;
    int          lat;

    vecs[0] = '{"and",      32'hF0F0_1234, 32'h0FF0_FFFF, 2'b00, 1'b0, 32'h00F0_1234, 1'b0, 1'b0};
    vecs[1] = '{"or",       32'h0000_00F0, 32'h0000_0F00, 2'b01, 1'b0, 32'h0000_0FF0, 1'b0, 1'b0};
    vecs[2] = '{"add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 2'b10, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
`ifdef ALU_SERIAL_OVF_EN
    vecs[3] = '{"sub_ovf",  32'h8000_0000, 32'h0000_0001, 2'b10, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[5] = '{"slt_ovf",  32'h7FFF_FFFF, 32'h8000_0000, 2'b11, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
`else
    vecs[3] = '{"sub_ovf",  32'h8000_0000, 32'h0000_0001, 2'b10, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0};
    vecs[5] = '{"slt_ovf",  32'h7FFF_FFFF, 32'h8000_0000, 2'b11, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
`endif
    vecs[4] = '{"slt_neg",  32'hFFFF_FFFB, 32'h0000_0003, 2'b11, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
    vecs[6] = '{"sub_eq",   32'h0000_0005, 32'h0000_0005, 2'b10, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7] = '{"slt_eq",   32'h1234_5678, 32'h1234_5678, 2'b11, 1'b0, 32'h0000_0000, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_start_ready", {31'b0, start_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].name, vecs[i].va, vecs[i].vb, vecs[i].op, vecs[i].neg,
            vecs[i].er, vecs[i].ez, vecs[i].eo);
    end

    // Random operations against the reference model
    for (int i = 0; i < 30; i++) begin
      ra   = $urandom;
      rb   = (i % 5 == 0) ? ra : 32'($urandom);
      if (i % 7 == 0) ra = {1'b1, ra[30:0]};
      if (i % 7 == 0) rb = {1'b0, rb[30:0]};
      rop  = 2'($urandom_range(0, 3));
      rneg = 1'($urandom_range(0, 1));
      model(ra, rb, rop, rneg, er, ez, eo);
      do_op($sformatf("rnd%0d", i), ra, rb, rop, rneg, er, ez, eo);
    end

    // Backpressure: hold result 5 cycles with a stray start pulse
    ra = 32'h1000_0000; rb = 32'h0000_0042;
    model(ra, rb, 2'b10, 1'b1, er, ez, eo);
    start_op(ra, rb, 2'b10, 1'b1);
    wait_done(lat);
    chk("bp_latency", 32'(lat), 32'(W));
    for (int c = 0; c < 5; c++) begin
      start_valid = (c == 2);
      a = 32'h0000_0001; b = 32'h0000_0001; alu_op = 2'b10; b_negate = 1'b0;
      @(posedge clk); #1;
      start_valid = 1'b0;
      chk("bp_result", result, er);
      chk("bp_zero", {31'b0, zero}, {31'b0, ez});
      chk("bp_overflow", {31'b0, overflow}, {31'b0, eo});
      chk("bp_valid", {31'b0, res_valid}, 32'd1);
      chk("bp_start_ready", {31'b0, start_ready}, 32'd0);
    end
    $display("txn backpressure result=%h held 5 cycles", result);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("bp_idle_ready", {31'b0, start_ready}, 32'd1);
    chk("bp_idle_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("bp_pulse_ignored", {31'b0, busy}, 32'd0);

    // Reset in the middle of RUN, then a clean ADD
    start_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 2'b10, 1'b0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("mid_busy_before_reset", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_valid", {31'b0, res_valid}, 32'd0);
    chk("mid_rst_ready", {31'b0, start_ready}, 32'd1);
    $display("txn reset_mid_run busy=%0d start_ready=%0d", busy, start_ready);
    do_op("add_after_reset", 32'd2, 32'd3, 2'b10, 1'b0, 32'd5, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
